// File: rtl/logic_gate_pkg.sv
// Shared definitions for the logic-gate library: default widths and the
// reduction helper used by the parity/compare outputs.
package logic_gate_pkg;

  localparam int GATE_DEFAULT_WIDTH = 1;
  localparam int GATE_MAX_WIDTH     = 64;

  // Callers zero-extend narrower vectors; the zero pad does not change parity.
  function automatic logic xor_reduce(input logic [GATE_MAX_WIDTH-1:0] vec);
    logic acc;
    acc = 1'b0;
    for (int i = 0; i < GATE_MAX_WIDTH; i++) begin
      acc = acc ^ vec[i];
    end
    return acc;
  endfunction

endpackage

// File: rtl/xor_comb.sv
// Purely combinational WIDTH-bit XOR with reduction parity and any-difference
// flags; no state, no clock.
module xor_comb
  import logic_gate_pkg::*;
#(
  parameter int WIDTH = GATE_DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  output logic             parity,
  output logic             diff_any
);

  logic [GATE_MAX_WIDTH-1:0] c_ext;

  // Each result bit sees only its own operand bits; no cross-bit paths.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      assign c[gi] = a[gi] ^ b[gi];
    end
  endgenerate

  always_comb begin
    c_ext            = '0;
    c_ext[WIDTH-1:0] = c;
  end

  assign parity   = xor_reduce(c_ext);
  assign diff_any = |c;

endmodule

// File: rtl/xor_gate.sv
// Registered (or optionally combinational) bitwise XOR leaf with a valid
// pipeline, reduction parity and mismatch flag.
module xor_gate
  import logic_gate_pkg::*;
#(
  parameter int WIDTH      = GATE_DEFAULT_WIDTH,
  parameter int REGISTERED = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  output logic             parity,
  output logic             out_valid,
  output logic             diff_any
);

  localparam bit USE_REG = (REGISTERED != 0);

  logic [WIDTH-1:0] c_next;
  logic             parity_next;
  logic             diff_any_next;

  logic [WIDTH-1:0] c_reg;
  logic             parity_reg;
  logic             diff_any_reg;
  logic             out_valid_reg;

  xor_comb #(
    .WIDTH (WIDTH)
  ) u_xor_comb (
    .a        (a),
    .b        (b),
    .c        (c_next),
    .parity   (parity_next),
    .diff_any (diff_any_next)
  );

  // Data registers only load on valid cycles so results persist across gaps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c_reg         <= '0;
      parity_reg    <= 1'b0;
      diff_any_reg  <= 1'b0;
      out_valid_reg <= 1'b0;
    end else begin
      out_valid_reg <= in_valid;
      if (in_valid) begin
        c_reg        <= c_next;
        parity_reg   <= parity_next;
        diff_any_reg <= diff_any_next;
      end
    end
  end

  // In combinational mode reset still has to force every output low at once.
  assign c         = USE_REG ? c_reg         : (rst ? '0   : c_next);
  assign parity    = USE_REG ? parity_reg    : (parity_next   & ~rst);
  assign diff_any  = USE_REG ? diff_any_reg  : (diff_any_next & ~rst);
  assign out_valid = USE_REG ? out_valid_reg : (in_valid      & ~rst);

endmodule

// File: tb/tb_xor_gate.sv
// Self-checking bench: three xor_gate instances (1-bit registered, 8-bit
// registered, 4-bit combinational) against a behavioural model.
module tb_xor_gate;

  logic clk;
  logic rst;

  logic       v1, v8, v4;
  logic [0:0] a1, b1;
  logic [7:0] a8, b8;
  logic [3:0] a4, b4;

  logic [0:0] c1;
  logic [7:0] c8;
  logic [3:0] c4;
  logic       p1, p8, p4;
  logic       ov1, ov8, ov4;
  logic       d1, d8, d4;

  int checks   = 0;
  int failures = 0;
  bit run_cmp  = 1'b0;

  xor_gate #(.WIDTH(1), .REGISTERED(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(v1), .a(a1), .b(b1),
    .c(c1), .parity(p1), .out_valid(ov1), .diff_any(d1)
  );

  xor_gate #(.WIDTH(8), .REGISTERED(1)) dut8 (
    .clk(clk), .rst(rst), .in_valid(v8), .a(a8), .b(b8),
    .c(c8), .parity(p8), .out_valid(ov8), .diff_any(d8)
  );

  xor_gate #(.WIDTH(4), .REGISTERED(0)) dut4 (
    .clk(clk), .rst(rst), .in_valid(v4), .a(a4), .b(b4),
    .c(c4), .parity(p4), .out_valid(ov4), .diff_any(d4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural model of the registered instances: last valid result held,
  // valid flag follows the previous cycle's in_valid, everything cleared by rst.
  logic [0:0] m1_c = '0;
  logic [7:0] m8_c = '0;
  logic       m1_p = 0, m8_p = 0, m1_d = 0, m8_d = 0, m1_ov = 0, m8_ov = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m1_c <= '0; m1_p <= 0; m1_d <= 0; m1_ov <= 0;
      m8_c <= '0; m8_p <= 0; m8_d <= 0; m8_ov <= 0;
    end else begin
      m1_ov <= v1;
      m8_ov <= v8;
      if (v1) begin
        m1_c <= a1 ^ b1;
        m1_p <= ($countones(a1 ^ b1) % 2) == 1;
        m1_d <= (a1 != b1);
      end
      if (v8) begin
        m8_c <= a8 ^ b8;
        m8_p <= ($countones(a8 ^ b8) % 2) == 1;
        m8_d <= (a8 != b8);
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of every instance against the model.
  always @(negedge clk) begin
    if (run_cmp) begin
      chk("cmp_c1",   64'(c1),  64'(m1_c));
      chk("cmp_p1",   64'(p1),  64'(m1_p));
      chk("cmp_d1",   64'(d1),  64'(m1_d));
      chk("cmp_ov1",  64'(ov1), 64'(m1_ov));
      chk("cmp_c8",   64'(c8),  64'(m8_c));
      chk("cmp_p8",   64'(p8),  64'(m8_p));
      chk("cmp_d8",   64'(d8),  64'(m8_d));
      chk("cmp_ov8",  64'(ov8), 64'(m8_ov));
      chk("cmp_c4",   64'(c4),  rst ? 64'd0 : 64'(a4 ^ b4));
      chk("cmp_p4",   64'(p4),  rst ? 64'd0 : 64'(($countones(a4 ^ b4) % 2) == 1));
      chk("cmp_d4",   64'(d4),  rst ? 64'd0 : 64'(a4 != b4));
      chk("cmp_ov4",  64'(ov4), 64'(v4 && !rst));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  logic [1:0] tt_in  [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
  logic       tt_out [4] = '{1'b0, 1'b1, 1'b1, 1'b0};

  initial begin
    rst = 1'b1;
    v1 = 1'b1; a1 = 1'b1; b1 = 1'b0;
    v8 = 1'b0; a8 = '0;   b8 = '0;
    v4 = 1'b0; a4 = '0;   b4 = '0;
    run_cmp = 1'b1;
    step();
    step();

    // Reset holds outputs low even with valid operands present.
    chk("rst_c1", 64'(c1), 64'd0);
    chk("rst_p1", 64'(p1), 64'd0);
    chk("rst_ov1", 64'(ov1), 64'd0);
    chk("rst_ov8", 64'(ov8), 64'd0);
    $display("txn reset: c1=%0h p1=%0b ov1=%0b", c1, p1, ov1);

    rst = 1'b0;
    step();
    chk("rel_c1", 64'(c1), 64'd1);
    chk("rel_ov1", 64'(ov1), 64'd1);
    $display("txn release: c1=%0h ov1=%0b", c1, ov1);

    // Exhaustive 1-bit truth table, each result one edge after its inputs.
    for (int i = 0; i < 4; i++) begin
      logic [1:0] pat;
      pat = tt_in[i];
      a1 = pat[1];
      b1 = pat[0];
      step();
      chk("tt_c", 64'(c1), 64'(tt_out[i]));
      chk("tt_p", 64'(p1), 64'(tt_out[i]));
      chk("tt_model", 64'(m1_c), 64'(tt_out[i]));
      $display("txn tt a=%0b b=%0b -> c=%0h p=%0b", pat[1], pat[0], c1, p1);
    end

    // Hold on invalid.
    v8 = 1'b1; a8 = 8'hF0; b8 = 8'h0F;
    step();
    chk("hold_c", 64'(c8), 64'hFF);
    chk("hold_p", 64'(p8), 64'd0);
    chk("hold_d", 64'(d8), 64'd1);
    chk("hold_model", 64'(m8_c), 64'hFF);
    $display("txn w8 F0^0F -> c=%0h p=%0b d=%0b", c8, p8, d8);
    v8 = 1'b0; a8 = 8'h00; b8 = 8'hFF;
    step();
    chk("hold_c2", 64'(c8), 64'hFF);
    chk("hold_ov", 64'(ov8), 64'd0);
    $display("txn w8 invalid -> c=%0h ov=%0b", c8, ov8);

    // Vector parity and compare.
    v8 = 1'b1; a8 = 8'hA5; b8 = 8'hA4;
    step();
    chk("vec_c", 64'(c8), 64'h01);
    chk("vec_p", 64'(p8), 64'd1);
    chk("vec_d", 64'(d8), 64'd1);
    $display("txn w8 A5^A4 -> c=%0h p=%0b d=%0b", c8, p8, d8);
    a8 = 8'h3C; b8 = 8'h3C;
    step();
    chk("eq_c", 64'(c8), 64'h00);
    chk("eq_p", 64'(p8), 64'd0);
    chk("eq_d", 64'(d8), 64'd0);
    chk("eq_model", 64'(m8_d), 64'd0);
    $display("txn w8 3C^3C -> c=%0h p=%0b d=%0b", c8, p8, d8);

    // Combinational instance responds within the same cycle.
    a4 = 4'h9; b4 = 4'h3; v4 = 1'b1;
    #1;
    chk("comb_c", 64'(c4), 64'hA);
    chk("comb_p", 64'(p4), 64'd0);
    chk("comb_ov", 64'(ov4), 64'd1);
    v4 = 1'b0;
    #1;
    chk("comb_ov0", 64'(ov4), 64'd0);
    $display("txn w4 9^3 -> c=%0h p=%0b", c4, p4);
    step();

    // Random streaming with an asynchronous reset pulse in the middle.
    for (int i = 0; i < 200; i++) begin
      v1 = 1'($urandom_range(0, 3) != 0);
      v8 = 1'($urandom_range(0, 3) != 0);
      v4 = 1'($urandom_range(0, 1));
      a1 = 1'($urandom); b1 = 1'($urandom);
      a8 = 8'($urandom); b8 = 8'($urandom);
      a4 = 4'($urandom); b4 = 4'($urandom);
      if (i == 100) begin
        #1 rst = 1'b1;
        #1;
        chk("arst_c8", 64'(c8), 64'd0);
        chk("arst_p8", 64'(p8), 64'd0);
        chk("arst_d8", 64'(d8), 64'd0);
        chk("arst_ov8", 64'(ov8), 64'd0);
        chk("arst_c1", 64'(c1), 64'd0);
        chk("arst_c4", 64'(c4), 64'd0);
        chk("arst_ov4", 64'(ov4), 64'd0);
        $display("txn async reset mid-stream: c8=%0h ov8=%0b", c8, ov8);
        step();
        chk("arst_noemit", 64'(ov8), 64'd0);
        rst = 1'b0;
      end else begin
        step();
      end
      $display("txn rnd %0d: a8=%0h b8=%0h v8=%0b -> c8=%0h ov8=%0b", i, a8, b8, v8, c8, ov8);
    end

    @(negedge clk);
    run_cmp = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
